// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin arbiter that shares one Four_Bit_Comparator
// among NREQ requesters and registers each result into a one-entry response
// buffer tagged with the requester ID.
// Optional feature: define COMP_ARB_STATS_EN to build the saturating
// completed-comparison counter on stat_count. Without it, stat_count is 0.
module comparator_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2:0]        rsp_id,
   output logic              rsp_g,
   output logic              rsp_e,
   output logic              rsp_s,
   output logic [7:0]        stat_count
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ptr;
   logic [NREQ-1:0]   grant;
   logic [2:0]        gid;
   logic              found;
   logic [3:0]        a_sel, b_sel;
   logic              cmp_g, cmp_e, cmp_s;
   logic              can_take;
   logic              accept;
   logic              drain;

   // Round-robin scan: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1;
   // the winner's operands are steered to the shared comparator
   always_comb begin
      grant = '0;
      gid   = '0;
      found = 1'b0;
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (i >= 32'(ptr))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gid      = 3'(i);
            a_sel    = req_a[4*i +: 4];
            b_sel    = req_b[4*i +: 4];
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && (i < 32'(ptr))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gid      = 3'(i);
            a_sel    = req_a[4*i +: 4];
            b_sel    = req_b[4*i +: 4];
         end
      end
   end

   Four_Bit_Comparator u_cmp (
      .a (a_sel),
      .b (b_sel),
      .g (cmp_g),
      .e (cmp_e),
      .s (cmp_s)
   );

   assign rsp_valid = (state_q == FULL);
   assign can_take  = (state_q == EMPTY) | rsp_ready;
   assign accept    = found & can_take & rst_n;
   assign drain     = rsp_valid & rsp_ready;
   assign req_ready = grant & {NREQ{accept}};

   // Next-state logic for the response buffer occupancy
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (drain && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Response buffer payload: loaded on accept, held otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_id <= '0;
         rsp_g  <= 1'b0;
         rsp_e  <= 1'b0;
         rsp_s  <= 1'b0;
      end else if (accept) begin
         rsp_id <= gid;
         rsp_g  <= cmp_g;
         rsp_e  <= cmp_e;
         rsp_s  <= cmp_s;
      end
   end

   // Priority pointer moves just past the accepted requester
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         if (32'(gid) == NREQ - 1) ptr <= '0;
         else                      ptr <= gid + 3'd1;
      end
   end

`ifdef COMP_ARB_STATS_EN
   logic [7:0] cnt;

   // Saturating count of drained responses
   always_ff @(posedge clk) begin
      if (!rst_n)                   cnt <= '0;
      else if (drain && cnt != '1)  cnt <= cnt + 8'd1;
   end

   assign stat_count = cnt;
`else
   assign stat_count = '0;
`endif

endmodule

// Unsigned 4-bit magnitude comparator; exactly one output is high
module Four_Bit_Comparator (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       g,
   output logic       e,
   output logic       s
);
   assign g = (a > b);
   assign e = (a == b);
   assign s = (a < b);
endmodule
